// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned-binary converter. Handles one digit per clock,
// most-significant first, with valid/ready handshakes on the input and output sides.
module bcd_to_bin #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_err
);

    // Three bits are enough to index the largest legal digit count (6).
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [4*DIGITS-1:0]   bcd_q,     bcd_d;
    logic [BIN_W-1:0]      acc_q,     acc_d;
    logic                  err_q,     err_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [BIN_W-1:0]      out_bin_q, out_bin_d;
    logic                  out_err_q, out_err_d;

    logic [3:0]            digit_s;
    logic [BIN_W-1:0]      mac_s;
    logic                  err_next_s;

    function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] v,
                                            input logic [IDX_W-1:0]    i);
        digit_at = v[{i, 2'b00} +: 4];
    endfunction

    // Multiply-accumulate step and error accumulation for the current digit.
    always_comb begin
        digit_s    = digit_at(bcd_q, idx_q);
        mac_s      = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit_s);
        err_next_s = err_q | (digit_s > 4'd9);
    end

    // Next-state and datapath update for the IDLE/CONV/DONE sequence.
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        acc_d     = acc_q;
        err_d     = err_q;
        idx_d     = idx_q;
        out_bin_d = out_bin_q;
        out_err_d = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d   = in_bcd;
                    acc_d   = '0;
                    err_d   = 1'b0;
                    idx_d   = IDX_W'(DIGITS - 1);
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                acc_d = mac_s;
                err_d = err_next_s;
                idx_d = idx_q - IDX_W'(1);
                // The result is published on the same edge that consumes the last digit.
                if (idx_q == IDX_W'(0)) begin
                    out_bin_d = err_next_s ? '0 : mac_s;
                    out_err_d = err_next_s;
                    state_d   = DONE;
                end else begin
                    state_d   = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bcd_q     <= '0;
            acc_q     <= '0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            out_bin_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            out_bin_q <= out_bin_d;
            out_err_q <= out_err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: a 2-digit and a 4-digit instance checked against
// hand-computed results, plus backpressure and mid-conversion reset sequences.
module tb_bcd_to_bin;

    logic        clk;
    logic        reset;

    logic        in_valid2,  in_ready2,  out_valid2, out_ready2, out_err2;
    logic [7:0]  in_bcd2;
    logic [6:0]  out_bin2;

    logic        in_valid4,  in_ready4,  out_valid4, out_ready4, out_err4;
    logic [15:0] in_bcd4;
    logic [13:0] out_bin4;

    int n_cmp;
    int n_fail;

    typedef struct {
        int          digits;
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        err;
    } vec_t;

    vec_t tbl [9];

    bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_bcd(in_bcd2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_bin(out_bin2), .out_err(out_err2)
    );

    bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_bcd(in_bcd4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_bin(out_bin4), .out_err(out_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion with out_ready held high; checks latency, result and return to IDLE.
    task automatic conv(input int d, input logic [15:0] bcd, input logic [13:0] eb,
                        input logic ee, input string nm);
        int t;
        int lat;
        t = 0;
        out_ready2 = 1'b1;
        out_ready4 = 1'b1;
        while (((d == 2) ? !in_ready2 : !in_ready4) && t < 20) begin
            tick();
            t++;
        end
        if (d == 2) begin
            in_bcd2 = bcd[7:0];
            in_valid2 = 1'b1;
        end else begin
            in_bcd4 = bcd;
            in_valid4 = 1'b1;
        end
        tick();
        in_valid2 = 1'b0;
        in_valid4 = 1'b0;
        in_bcd2   = 8'hFF;
        in_bcd4   = 16'hFFFF;
        lat = 0;
        while (((d == 2) ? !out_valid2 : !out_valid4) && lat < 20) begin
            tick();
            lat++;
        end
        chk({nm, " latency"}, lat, d);
        if (d == 2) begin
            chk({nm, " out_bin"}, {25'd0, out_bin2}, {18'd0, eb});
            chk({nm, " out_err"}, {31'd0, out_err2}, {31'd0, ee});
        end else begin
            chk({nm, " out_bin"}, {18'd0, out_bin4}, {18'd0, eb});
            chk({nm, " out_err"}, {31'd0, out_err4}, {31'd0, ee});
        end
        tick();
        chk({nm, " in_ready after"}, {31'd0, (d == 2) ? in_ready2 : in_ready4}, 32'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        tbl[0] = '{2, 16'h0042, 14'd42,   1'b0};
        tbl[1] = '{2, 16'h0000, 14'd0,    1'b0};
        tbl[2] = '{2, 16'h0099, 14'd99,   1'b0};
        tbl[3] = '{2, 16'h0001, 14'd1,    1'b0};
        tbl[4] = '{2, 16'h001A, 14'd0,    1'b1};
        tbl[5] = '{2, 16'h0027, 14'd27,   1'b0};
        tbl[6] = '{4, 16'h9999, 14'd9999, 1'b0};
        tbl[7] = '{4, 16'h2024, 14'd2024, 1'b0};
        tbl[8] = '{4, 16'h0F00, 14'd0,    1'b1};

        reset = 1'b0;
        in_valid2 = 1'b0; in_bcd2 = 8'h00; out_ready2 = 1'b1;
        in_valid4 = 1'b0; in_bcd4 = 16'h0000; out_ready4 = 1'b1;
        #12;
        chk("reset in_ready",  {31'd0, in_ready2},  32'd1);
        chk("reset out_valid", {31'd0, out_valid2}, 32'd0);
        chk("reset out_bin",   {25'd0, out_bin2},   32'd0);
        chk("reset out_err",   {31'd0, out_err2},   32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            conv(tbl[i].digits, tbl[i].bcd, tbl[i].bin, tbl[i].err, $sformatf("vec%0d", i));
        end

        // Backpressure: result held, new input refused until the output handshake.
        out_ready2 = 1'b0;
        in_bcd2 = 8'h58;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        tick();
        tick();
        chk("bp out_valid rise", {31'd0, out_valid2}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            in_bcd2 = 8'h11;
            in_valid2 = 1'b1;
            tick();
            chk("bp out_valid held", {31'd0, out_valid2}, 32'd1);
            chk("bp out_bin held",   {25'd0, out_bin2},   32'd58);
            chk("bp in_ready low",   {31'd0, in_ready2},  32'd0);
        end
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        tick();
        chk("bp out_valid drop", {31'd0, out_valid2}, 32'd0);
        chk("bp in_ready back",  {31'd0, in_ready2},  32'd1);
        chk("bp out_bin kept",   {25'd0, out_bin2},   32'd58);
        conv(2, 16'h0011, 14'd11, 1'b0, "bp next");

        // Reset after one CONV edge discards the pending 73.
        in_bcd2 = 8'h73;
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid2}, 32'd0);
        chk("rst out_bin",   {25'd0, out_bin2},   32'd0);
        chk("rst in_ready",  {31'd0, in_ready2},  32'd1);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst no stale valid", {31'd0, out_valid2}, 32'd0);
        end
        conv(2, 16'h0005, 14'd5, 1'b0, "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential packed-BCD to unsigned-binary converter. It is the reverse of the counter/display path, which produces BCD for the seven-segment decoders.
- Takes a user-entered or stored BCD value (e.g. a day number from switches) and converts it to binary for comparison or arithmetic logic.
- Processes one decimal digit per clock, most-significant first, using acc = acc*10 + digit.
- Uses valid/ready handshakes on both sides.

Parameters:
- DIGITS, 2, number of BCD digits on in_bcd; legal range 1..6.
- BIN_W, 7, width of out_bin; must satisfy 2^BIN_W > 10^DIGITS - 1 (7 for 2 digits, 14 for 4 digits).

Ports:
- clk  input  1  conversion clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bcd holds a value to convert.
- in_ready  output  1  block can accept a value (IDLE only).
- in_bcd  input  4*DIGITS  packed BCD; digit i = in_bcd[4*i+3:4*i]; digit DIGITS-1 is most significant.
- out_valid  output  1  out_bin/out_err hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_bin  output  BIN_W  binary value of in_bcd; forced 0 when out_err=1.
- out_err  output  1  at least one input digit was > 9.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, in_ready=1, out_valid=0, out_bin=0, out_err=0.
  - Accumulator, digit index and captured-input register cleared.
  - Release is synchronous to the next clk edge.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture in_bcd into an internal register, clear the accumulator and error flag, set digit index to DIGITS-1, go to CONV.
  - in_bcd may change freely after the capture edge.
- CONV:
  - in_ready=0, out_valid=0.
  - Each edge: acc <= (acc<<3) + (acc<<1) + digit[idx], truncated to BIN_W bits.
  - Each edge: err <= err | (digit[idx] > 9).
  - Each edge: idx decrements. On the edge that processes idx=0, go to DONE.
  - Exactly DIGITS edges are spent in CONV.
- DONE:
  - out_valid=1; out_bin=acc (or 0 if err); out_err=err.
  - out_bin and out_err stay stable while out_valid=1 and out_ready=0, with no limit on backpressure duration.
  - On an edge with out_ready=1: go to IDLE, out_valid=0. out_bin/out_err keep their last values until the next result.
- Latency: input handshake on edge N → out_valid=1 after edge N+DIGITS. With out_ready held at 1, a new input can be accepted on edge N+DIGITS+2, giving a throughput of one conversion per DIGITS+2 cycles.
- in_valid outside IDLE is ignored; in_ready=0 there, so no handshake occurs.
- out_ready outside DONE is ignored.
- Invalid digits (A–F) do not stop the conversion. Arithmetic continues mod 2^BIN_W, and the result is replaced by 0 with out_err=1.
- No internal overflow for valid input: the BIN_W constraint guarantees 10^DIGITS-1 fits.
- Reset asserted mid-CONV or in DONE: immediate return to the reset values. The pending result is discarded and no out_valid pulse occurs.
- There are no combinational paths from inputs to outputs; all outputs are registered or decoded from state.

Test Plan:
- DIGITS=2: in_bcd=8'h42 with in_valid for 1 cycle, out_ready=1 → out_valid high exactly 2 edges after the handshake, out_bin=42 (7'h2A), out_err=0; in_ready back to 1 one cycle after the output handshake.
- DIGITS=2 boundaries: in_bcd=8'h00 → out_bin=0; in_bcd=8'h99 → out_bin=99 (7'h63); in_bcd=8'h01 → out_bin=1. All with out_err=0.
- Invalid digit: in_bcd=8'h1A → out_err=1, out_bin=0. Then in_bcd=8'h27 → out_err=0, out_bin=27, confirming the error flag clears per conversion.
- Backpressure: in_bcd=8'h58, out_ready=0 for 5 cycles after out_valid rises → out_bin=58 held stable, in_ready=0, and in_valid pulses with 8'h11 are not accepted. Raise out_ready → one output handshake, then 8'h11 is accepted → out_bin=11.
- Reset mid-operation: accept 8'h73, assert reset after 1 CONV edge → out_valid=0, out_bin=0, in_ready=1 immediately. After release, 8'h05 converts to 5 with no stale 73 output.
- DIGITS=4, BIN_W=14: in_bcd=16'h9999 → out_bin=9999 after 4 edges; in_bcd=16'h2024 → 2024; in_bcd=16'h0F00 → out_err=1, out_bin=0.
